alu_operand_dispatch: RTL and testbench



---
 rtl/alu_operand_dispatch_if.sv | 12 +
 rtl/alu_operand_dispatch.sv | 166 ++++++++++++++++
 tb/tb_alu_operand_dispatch.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_dispatch_if.sv
// Valid/ack data channel shared by the ALU dispatch command, operand and result ports.
// Transfers happen on any clock edge where valid and ack are both high.
interface data_interface #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport producer (output valid, output data, input ack);
  modport consumer (input valid, input data, output ack);
endinterface

// File: rtl/alu_operand_dispatch.sv
// Pulls one opcode and its 0/1/2 operands in stream order and issues operator/left/right
// as independent registered producers. Optional sticky illegal_opcode port: ALU_DISPATCH_ILLEGAL_FLAG_EN.
module alu_operand_dispatch #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic            clock,
  input  logic            reset,
  data_interface.consumer command,
  data_interface.consumer operand,
  data_interface.producer operator,
  data_interface.producer left,
  data_interface.producer right
`ifdef ALU_DISPATCH_ILLEGAL_FLAG_EN
  ,
  output logic            illegal_opcode
`endif
);

  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_NOP1 = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_NOP2 = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_DUP  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_SWAP = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_NOT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_AND  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] ALU_OP_OR   = OPCODE_WIDTH'(6);

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    IDLE,
    GATHER_LEFT,
    GATHER_RIGHT,
    ISSUE
  } state_t;

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] opc);
    return (opc == ALU_OP_NOP1) || (opc == ALU_OP_DUP) || (opc == ALU_OP_NOT) ||
           (opc == ALU_OP_NOP2) || (opc == ALU_OP_SWAP) || (opc == ALU_OP_AND) ||
           (opc == ALU_OP_OR);
  endfunction

  function automatic logic is_two_op(input logic [OPCODE_WIDTH-1:0] opc);
    return (opc == ALU_OP_NOP2) || (opc == ALU_OP_SWAP) || (opc == ALU_OP_AND) ||
           (opc == ALU_OP_OR);
  endfunction

  state_t                  state_reg, state_next;
  logic [OPCODE_WIDTH-1:0] opcode_reg, opcode_next;
  logic [DATA_WIDTH-1:0]   left_stage_reg, left_stage_next;
  logic [DATA_WIDTH-1:0]   right_stage_reg, right_stage_next;
  logic [OPCODE_WIDTH-1:0] cmd_opcode;
  logic                    two_op;
  logic                    issue_fire;

  // Output channel registers, index 0=operator, 1=left, 2=right.
  logic [NUM_CH-1:0]       ch_valid_reg;
  logic [DATA_WIDTH-1:0]   ch_data_reg  [NUM_CH];
  logic [DATA_WIDTH-1:0]   ch_load_data [NUM_CH];
  logic [NUM_CH-1:0]       ch_ack, ch_need, ch_free, ch_load;

  assign cmd_opcode = command.data[OPCODE_WIDTH-1:0];
  assign two_op     = is_two_op(opcode_reg);

  // Acks are gated by reset so nothing is consumed in a cycle whose state is being discarded.
  assign command.ack = !reset && (state_reg == IDLE) && command.valid;
  assign operand.ack = !reset && ((state_reg == GATHER_LEFT) || (state_reg == GATHER_RIGHT)) &&
                       operand.valid;

  assign ch_ack          = {right.ack, left.ack, operator.ack};
  assign ch_need         = {two_op, 1'b1, 1'b1};
  assign ch_load_data[0] = DATA_WIDTH'(opcode_reg);
  assign ch_load_data[1] = left_stage_reg;
  assign ch_load_data[2] = right_stage_reg;
  assign issue_fire      = (state_reg == ISSUE) && (&(ch_free | ~ch_need));

  always_comb begin
    state_next       = state_reg;
    opcode_next      = opcode_reg;
    left_stage_next  = left_stage_reg;
    right_stage_next = right_stage_reg;
    case (state_reg)
      IDLE: begin
        if (command.ack && is_legal(cmd_opcode)) begin
          opcode_next = cmd_opcode;
          state_next  = GATHER_LEFT;
        end
      end
      GATHER_LEFT: begin
        if (operand.ack) begin
          left_stage_next = operand.data;
          state_next      = two_op ? GATHER_RIGHT : ISSUE;
        end
      end
      GATHER_RIGHT: begin
        if (operand.ack) begin
          right_stage_next = operand.data;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      opcode_reg      <= '0;
      left_stage_reg  <= '0;
      right_stage_reg <= '0;
    end else begin
      state_reg       <= state_next;
      opcode_reg      <= opcode_next;
      left_stage_reg  <= left_stage_next;
      right_stage_reg <= right_stage_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_channel
      assign ch_free[gi] = !ch_valid_reg[gi] || ch_ack[gi];
      assign ch_load[gi] = issue_fire && ch_need[gi];

      // A load in the same cycle as an ack wins, allowing back-to-back bundles.
      always_ff @(posedge clock) begin
        if (reset) begin
          ch_valid_reg[gi] <= 1'b0;
          ch_data_reg[gi]  <= '0;
        end else if (ch_load[gi]) begin
          ch_valid_reg[gi] <= 1'b1;
          ch_data_reg[gi]  <= ch_load_data[gi];
        end else if (ch_valid_reg[gi] && ch_ack[gi]) begin
          ch_valid_reg[gi] <= 1'b0;
          ch_data_reg[gi]  <= '0;
        end
      end
    end
  endgenerate

  assign operator.valid = ch_valid_reg[0];
  assign operator.data  = ch_data_reg[0];
  assign left.valid     = ch_valid_reg[1];
  assign left.data      = ch_data_reg[1];
  assign right.valid    = ch_valid_reg[2];
  assign right.data     = ch_data_reg[2];

`ifdef ALU_DISPATCH_ILLEGAL_FLAG_EN
  logic illegal_flag_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_flag_reg <= 1'b0;
    end else if (command.ack && !is_legal(cmd_opcode)) begin
      illegal_flag_reg <= 1'b1;
    end
  end

  assign illegal_opcode = illegal_flag_reg;
`endif

endmodule

// File: tb/tb_alu_operand_dispatch.sv
// Bench for alu_operand_dispatch: directed scenarios plus randomized backpressure checked
// against an opcode/operand-count reference model.
module tb_alu_operand_dispatch;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_interface #(.DATA_WIDTH(32)) cmd_if ();
  data_interface #(.DATA_WIDTH(32)) opd_if ();
  data_interface #(.DATA_WIDTH(32)) op_if ();
  data_interface #(.DATA_WIDTH(32)) left_if ();
  data_interface #(.DATA_WIDTH(32)) right_if ();
`ifdef ALU_DISPATCH_ILLEGAL_FLAG_EN
  logic illegal_opcode;
`endif

  alu_operand_dispatch #(.DATA_WIDTH(32), .OPCODE_WIDTH(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .command (cmd_if),
    .operand (opd_if),
    .operator(op_if),
    .left    (left_if),
    .right   (right_if)
`ifdef ALU_DISPATCH_ILLEGAL_FLAG_EN
    ,
    .illegal_opcode(illegal_opcode)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] cmd_q[$], opd_q[$];
  logic [31:0] got_op[$], got_left[$], got_right[$];
  logic [31:0] exp_op[$], exp_left[$], exp_right[$];
  bit rand_mode = 1'b0, rst_req = 1'b1;
  bit cmd_en = 1'b0, opd_en = 1'b0, ack_op_en = 1'b0, ack_left_en = 1'b0, ack_right_en = 1'b0;
  int stable_err = 0, both_ack_err = 0;
  bit [2:0] hold_prev = '0;
  logic [31:0] data_prev[3];

  // One clock of stimulus: drive at negedge, sample 1ns later, record transfers.
  task automatic cycle();
    logic [2:0] v, a;
    logic [31:0] d[3];
    @(negedge clock);
    reset = rst_req;
    if (rand_mode) begin
      cmd_en       = ($urandom_range(3) != 0);
      opd_en       = ($urandom_range(3) != 0);
      ack_op_en    = ($urandom_range(3) != 0);
      ack_left_en  = ($urandom_range(3) != 0);
      ack_right_en = ($urandom_range(3) != 0);
    end
    cmd_if.valid  = cmd_en && (cmd_q.size() > 0);
    cmd_if.data   = (cmd_q.size() > 0) ? cmd_q[0] : 32'd0;
    opd_if.valid  = opd_en && (opd_q.size() > 0);
    opd_if.data   = (opd_q.size() > 0) ? opd_q[0] : 32'd0;
    op_if.ack     = ack_op_en;
    left_if.ack   = ack_left_en;
    right_if.ack  = ack_right_en;
    #1;
    if (cmd_if.valid && cmd_if.ack) void'(cmd_q.pop_front());
    if (opd_if.valid && opd_if.ack) void'(opd_q.pop_front());
    if (cmd_if.ack && opd_if.ack) both_ack_err++;
    v = {right_if.valid, left_if.valid, op_if.valid};
    a = {right_if.ack, left_if.ack, op_if.ack};
    d[0] = op_if.data; d[1] = left_if.data; d[2] = right_if.data;
    for (int c = 0; c < 3; c++) begin
      if (hold_prev[c] && (!v[c] || d[c] !== data_prev[c])) stable_err++;
      hold_prev[c] = v[c] && !a[c] && !reset;
      data_prev[c] = d[c];
    end
    if (!reset) begin
      if (v[0] && a[0]) got_op.push_back(d[0]);
      if (v[1] && a[1]) got_left.push_back(d[1]);
      if (v[2] && a[2]) got_right.push_back(d[2]);
    end
  endtask

  task automatic clear_sb();
    cmd_q.delete(); opd_q.delete();
    got_op.delete(); got_left.delete(); got_right.delete();
    exp_op.delete(); exp_left.delete(); exp_right.delete();
  endtask

  // Reference model: each legal opcode takes 1 or 2 operands in stream order; others are dropped.
  task automatic build_expected(input logic [31:0] cmds[$], input logic [31:0] opds[$]);
    int k = 0;
    logic [5:0] opc;
    int n;
    foreach (cmds[i]) begin
      opc = cmds[i][5:0];
      case (opc)
        6'd0, 6'd2, 6'd4:       n = 1;
        6'd1, 6'd3, 6'd5, 6'd6: n = 2;
        default:                n = 0;
      endcase
      if (n > 0) begin
        exp_op.push_back({26'd0, opc});
        exp_left.push_back(opds[k]); k++;
        if (n == 2) begin exp_right.push_back(opds[k]); k++; end
      end
    end
  endtask

  task automatic test_reset();
    rst_req = 1'b1; cmd_en = 1'b1; opd_en = 1'b1;
    ack_op_en = 1'b1; ack_left_en = 1'b1; ack_right_en = 1'b1;
    cmd_q.push_back(32'd5); opd_q.push_back(32'd1);
    cycle(); cycle();
    checks++;
    if ({cmd_if.ack, opd_if.ack} !== 2'b00) begin
      failures++; $display("FAIL reset_acks: got %b want 00", {cmd_if.ack, opd_if.ack});
    end
    checks++;
    if ({right_if.valid, left_if.valid, op_if.valid} !== 3'b000) begin
      failures++; $display("FAIL reset_valid: got %b want 000", {right_if.valid, left_if.valid, op_if.valid});
    end
    checks++;
    if ((op_if.data | left_if.data | right_if.data) !== 32'd0) begin
      failures++; $display("FAIL reset_data: got %h/%h/%h want 0", op_if.data, left_if.data, right_if.data);
    end
    clear_sb();
    rst_req = 1'b0;
  endtask

  task automatic test_and_latency();
    clear_sb();
    cmd_q.push_back(32'd5);
    opd_q.push_back(32'hF0F0_F0F0); opd_q.push_back(32'h0FF0_0FF0);
    cycle();
    checks++;
    if (cmd_if.ack !== 1'b1) begin failures++; $display("FAIL and_cmd_ack: got %b want 1", cmd_if.ack); end
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 3) begin
        checks++;
        if ({right_if.valid, left_if.valid, op_if.valid} !== 3'b000) begin
          failures++; $display("FAIL and_early_valid: cycle 3 got %b want 000", {right_if.valid, left_if.valid, op_if.valid});
        end
      end
      if (i == 4) begin
        checks++;
        if ({right_if.valid, left_if.valid, op_if.valid} !== 3'b111) begin
          failures++; $display("FAIL and_valid_c4: got %b want 111", {right_if.valid, left_if.valid, op_if.valid});
        end
        checks++;
        if (op_if.data !== 32'd5 || left_if.data !== 32'hF0F0_F0F0 || right_if.data !== 32'h0FF0_0FF0) begin
          failures++; $display("FAIL and_data: got %h/%h/%h want 5/f0f0f0f0/0ff00ff0", op_if.data, left_if.data, right_if.data);
        end
      end
      if (i == 5) begin
        checks++;
        if ({right_if.valid, left_if.valid, op_if.valid} !== 3'b000) begin
          failures++; $display("FAIL and_after_ack: got %b want 000", {right_if.valid, left_if.valid, op_if.valid});
        end
      end
    end
    checks++;
    if (got_op.size() != 1 || got_right.size() != 1) begin
      failures++; $display("FAIL and_transfers: got op=%0d right=%0d want 1/1", got_op.size(), got_right.size());
    end
  endtask

  task automatic test_not();
    int right_seen = 0;
    clear_sb();
    cmd_q.push_back(32'd4); opd_q.push_back(32'h1234_5678);
    for (int i = 0; i <= 6; i++) begin
      cycle();
      if (right_if.valid) right_seen++;
      if (i == 2) begin
        checks++;
        if (op_if.valid !== 1'b0) begin failures++; $display("FAIL not_early: cycle 2 op valid %b want 0", op_if.valid); end
      end
      if (i == 3) begin
        checks++;
        if ({left_if.valid, op_if.valid} !== 2'b11 || op_if.data !== 32'd4 || left_if.data !== 32'h1234_5678) begin
          failures++; $display("FAIL not_c3: got v=%b op=%h left=%h want 11/4/12345678", {left_if.valid, op_if.valid}, op_if.data, left_if.data);
        end
      end
      if (i == 4) begin
        checks++;
        if (op_if.valid !== 1'b0 || op_if.data !== 32'd0 || left_if.data !== 32'd0) begin
          failures++; $display("FAIL not_clear: got v=%b op=%h left=%h want 0/0/0", op_if.valid, op_if.data, left_if.data);
        end
      end
    end
    checks++;
    if (right_seen != 0) begin failures++; $display("FAIL not_right: right valid %0d cycles want 0", right_seen); end
  endtask

  task automatic test_swap_stall();
    clear_sb();
    ack_right_en = 1'b0;
    cmd_q.push_back(32'd3); cmd_q.push_back(32'd5);
    opd_q.push_back(32'hA); opd_q.push_back(32'hB); opd_q.push_back(32'hC); opd_q.push_back(32'hD);
    for (int i = 0; i < 14; i++) cycle();
    checks++;
    if (got_op.size() != 1 || op_if.valid !== 1'b0) begin
      failures++; $display("FAIL swap_stall_op: got %0d op transfers, op valid %b want 1/0", got_op.size(), op_if.valid);
    end
    checks++;
    if (right_if.valid !== 1'b1 || right_if.data !== 32'hB) begin
      failures++; $display("FAIL swap_right_held: got v=%b d=%h want 1/b", right_if.valid, right_if.data);
    end
    checks++;
    if (opd_q.size() != 0) begin failures++; $display("FAIL swap_gathered: operands left %0d want 0", opd_q.size()); end
    ack_right_en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (got_op.size() != 2 || got_op[0] !== 32'd3 || got_op[1] !== 32'd5) begin
      failures++; $display("FAIL swap_then_and_op: got %0d ops want 3 then 5", got_op.size());
    end
    checks++;
    if (got_left.size() != 2 || got_right.size() != 2 || got_left[1] !== 32'hC || got_right[0] !== 32'hB ||
        got_right[1] !== 32'hD) begin
      failures++; $display("FAIL swap_then_and_data: got left=%0d right=%0d transfers want a,c / b,d", got_left.size(), got_right.size());
    end
  endtask

  task automatic test_illegal();
    clear_sb();
    cmd_q.push_back(32'h0000_003F); cmd_q.push_back(32'd0);
    opd_q.push_back(32'hA5);
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i == 1) begin
        checks++;
        if (op_if.valid !== 1'b0) begin failures++; $display("FAIL illegal_no_output: op valid %b want 0", op_if.valid); end
      end
`ifdef ALU_DISPATCH_ILLEGAL_FLAG_EN
      if (i <= 1) begin
        checks++;
        if (illegal_opcode !== (i == 1)) begin
          failures++; $display("FAIL illegal_flag: cycle %0d got %b want %0d", i, illegal_opcode, (i == 1));
        end
      end
`endif
    end
    checks++;
    if (cmd_q.size() != 0 || got_op.size() != 1 || got_right.size() != 0) begin
      failures++; $display("FAIL illegal_counts: cmds left %0d ops %0d rights %0d want 0/1/0", cmd_q.size(), got_op.size(), got_right.size());
    end else begin
      checks++;
      if (got_op[0] !== 32'd0 || got_left[0] !== 32'hA5) begin
        failures++; $display("FAIL illegal_nop1: got op=%h left=%h want 0/a5", got_op[0], got_left[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    ack_op_en = 1'b0; ack_left_en = 1'b0; ack_right_en = 1'b0;
    cmd_q.push_back(32'd4); cmd_q.push_back(32'd6);
    opd_q.push_back(32'h77); opd_q.push_back(32'h11);
    for (int i = 0; i <= 4; i++) cycle();
    checks++;
    if (opd_q.size() != 0 || op_if.valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_setup: operands left %0d op valid %b want 0/1", opd_q.size(), op_if.valid);
    end
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    ack_op_en = 1'b1; ack_left_en = 1'b1; ack_right_en = 1'b1;
    cmd_q.push_back(32'd6); opd_q.push_back(32'h3); opd_q.push_back(32'h5);
    cycle();
    checks++;
    if ({right_if.valid, left_if.valid, op_if.valid} !== 3'b000 || left_if.data !== 32'd0) begin
      failures++; $display("FAIL rstmid_outputs: got v=%b left=%h want 000/0", {right_if.valid, left_if.valid, op_if.valid}, left_if.data);
    end
    checks++;
    if (cmd_if.ack !== 1'b1) begin failures++; $display("FAIL rstmid_idle: cmd ack %b want 1", cmd_if.ack); end
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (got_op.size() != 1 || got_right.size() != 1) begin
      failures++; $display("FAIL rstmid_counts: ops %0d rights %0d want 1/1", got_op.size(), got_right.size());
    end else begin
      checks++;
      if (got_op[0] !== 32'd6 || got_left[0] !== 32'h3 || got_right[0] !== 32'h5) begin
        failures++; $display("FAIL rstmid_or: got %h/%h/%h want 6/3/5", got_op[0], got_left[0], got_right[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [5:0] opc;
    int n = 0, bad = 0;
    clear_sb();
    for (int i = 0; i < 1000; i++) begin
      opc = ($urandom_range(19) == 0) ? 6'($urandom_range(63, 7)) : 6'($urandom_range(6));
      w = $urandom; w[5:0] = opc;
      cmd_q.push_back(w);
      if (opc <= 6'd6) begin
        opd_q.push_back($urandom);
        if (opc == 6'd1 || opc == 6'd3 || opc == 6'd5 || opc == 6'd6) opd_q.push_back($urandom);
      end
    end
    build_expected(cmd_q, opd_q);
    rand_mode = 1'b1;
    while ((got_op.size() < exp_op.size() || got_left.size() < exp_left.size() ||
            got_right.size() < exp_right.size()) && n < 40000) begin
      cycle();
      n++;
    end
    rand_mode = 1'b0;
    checks++;
    if (got_op.size() != exp_op.size() || got_left.size() != exp_left.size() ||
        got_right.size() != exp_right.size()) begin
      failures++;
      $display("FAIL random_counts: got %0d/%0d/%0d want %0d/%0d/%0d after %0d cycles", got_op.size(),
               got_left.size(), got_right.size(), exp_op.size(), exp_left.size(), exp_right.size(), n);
    end
    for (int i = 0; i < got_op.size() && i < exp_op.size(); i++) begin
      checks++;
      if (got_op[i] !== exp_op[i] || got_left[i] !== exp_left[i]) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL random_bundle %0d: got op=%h left=%h want %h/%h", i, got_op[i], got_left[i], exp_op[i], exp_left[i]);
      end
    end
    for (int i = 0; i < got_right.size() && i < exp_right.size(); i++) begin
      checks++;
      if (got_right[i] !== exp_right[i]) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL random_right %0d: got %h want %h", i, got_right[i], exp_right[i]);
      end
    end
    checks++;
    if (stable_err != 0) begin failures++; $display("FAIL hold_stable: %0d changes while valid && !ack want 0", stable_err); end
    checks++;
    if (both_ack_err != 0) begin failures++; $display("FAIL dual_ack: %0d cycles with both acks want 0", both_ack_err); end
  endtask

  initial begin
    cmd_if.valid = 1'b0; cmd_if.data = '0;
    opd_if.valid = 1'b0; opd_if.data = '0;
    op_if.ack = 1'b0; left_if.ack = 1'b0; right_if.ack = 1'b0;
    test_reset();
    test_and_latency();
    test_not();
    test_swap_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
